// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with valid/ready load, enable, abort and optional auto-reload.
// Decrement is a ripple-borrow chain of full_adder cells computing count + all-ones.
module down_counter_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             auto_reload,
   input  logic             en,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_count, w_count_nxt;
   logic [WIDTH-1:0] r_reload, w_reload_nxt;
   logic             r_ar, w_ar_nxt;
   logic             r_tc, w_tc_nxt;

   logic [WIDTH-1:0] w_dec;
   logic [WIDTH:0]   w_carry;
   logic             w_count_is_one;

   assign w_carry[0] = 1'b0;

   for (genvar g = 0; g < WIDTH; g++) begin : g_dec
      full_adder u_fa (
         .i_a   (r_count[g]),
         .i_b   (1'b1),
         .i_cin (w_carry[g]),
         .o_sum (w_dec[g]),
         .o_cout(w_carry[g+1])
      );
   end

   // Carry-out is set exactly when count != 0, so a zero difference with carry means count == 1.
   assign w_count_is_one = w_carry[WIDTH] && (w_dec == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_ar     <= 1'b0;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_ar     <= w_ar_nxt;
         r_tc     <= w_tc_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_ar_nxt     = r_ar;
      w_tc_nxt     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (load_valid) begin
               w_count_nxt  = load_value;
               w_reload_nxt = load_value;
               w_ar_nxt     = auto_reload;
               if (load_value != '0) w_state_nxt = RUN;
               else                  w_tc_nxt    = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (en) begin
               if (w_count_is_one) begin
                  w_tc_nxt = 1'b1;
                  if (r_ar) begin
                     w_count_nxt = r_reload;
                  end else begin
                     w_count_nxt = '0;
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_count_nxt = w_dec;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign count      = r_count;
   assign tc         = r_tc;
   assign busy       = (r_state == RUN);
   assign load_ready = (r_state == IDLE);

endmodule

// One-bit full adder cell used to build the decrement chain.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed vector table, corner sequences,
// then random stimulus against a behavioural model.
module tb_down_counter_timer;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] load_value;
   logic         auto_reload;
   logic         en;
   logic         abort;
   logic [W-1:0] count;
   logic         busy;
   logic         tc;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   bit       m_run;
   int       m_cnt;
   int       m_rel;
   bit       m_ar;
   bit       m_tc;

   typedef struct {
      bit       lv;
      int       lval;
      bit       ar;
      bit       e;
      bit       ab;
      int       exp_count;
      bit       exp_busy;
      bit       exp_tc;
   } vec_t;

   vec_t vecs[$];

   down_counter_timer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .auto_reload(auto_reload),
      .en         (en),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .tc         (tc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_cnt = 0; m_rel = 0; m_ar = 0; m_tc = 0;
   endtask

   task automatic model_edge(input bit lv, input int lval, input bit ar, input bit e, input bit ab);
      m_tc = 0;
      if (!m_run) begin
         if (lv) begin
            m_cnt = lval; m_rel = lval; m_ar = ar;
            if (lval == 0) m_tc = 1;
            else           m_run = 1;
         end
      end else if (ab) begin
         m_run = 0;
      end else if (e) begin
         if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
         end else begin
            m_tc = 1;
            if (m_ar) m_cnt = m_rel;
            else begin m_cnt = 0; m_run = 0; end
         end
      end
   endtask

   task automatic check_model(input string name);
      check({name, ".count"}, 32'(count), 32'(m_cnt));
      check({name, ".busy"}, 32'(busy), 32'(m_run));
      check({name, ".tc"}, 32'(tc), 32'(m_tc));
      check({name, ".ready"}, 32'(load_ready), 32'(!m_run));
   endtask

   task automatic step(input bit lv, input int lval, input bit ar, input bit e, input bit ab);
      load_valid  = lv;
      load_value  = W'(lval);
      auto_reload = ar;
      en          = e;
      abort       = ab;
      @(posedge clk);
      #1;
      model_edge(lv, lval, ar, e, ab);
   endtask

   task automatic add(input bit lv, input int lval, input bit ar, input bit e, input bit ab,
                      input int c, input bit b, input bit t);
      vec_t v;
      v.lv = lv; v.lval = lval; v.ar = ar; v.e = e; v.ab = ab;
      v.exp_count = c; v.exp_busy = b; v.exp_tc = t;
      vecs.push_back(v);
   endtask

   initial begin
      // load 5, no reload: 5,4,3,2,1,0 with tc in the zero cycle
      add(1, 5, 0, 1, 0, 5, 1, 0);
      add(0, 0, 0, 1, 0, 4, 1, 0);
      add(0, 0, 0, 1, 0, 3, 1, 0);
      add(0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      // load 3 with auto-reload, then abort
      add(1, 3, 1, 1, 0, 3, 1, 0);
      for (int k = 0; k < 3; k++) begin
         add(0, 0, 0, 1, 0, 2, 1, 0);
         add(0, 0, 0, 1, 0, 1, 1, 0);
         add(0, 0, 0, 1, 0, 3, 1, 1);
      end
      add(0, 0, 0, 1, 1, 3, 0, 0);
      // load 4, enable gap with an ignored load of 9
      add(1, 4, 0, 1, 0, 4, 1, 0);
      add(0, 0, 0, 1, 0, 3, 1, 0);
      add(1, 9, 1, 0, 0, 3, 1, 0);
      add(1, 9, 1, 0, 0, 3, 1, 0);
      add(0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 0);
      // load 6, abort at 2, then zero load
      add(1, 6, 0, 1, 0, 6, 1, 0);
      add(0, 0, 0, 1, 0, 5, 1, 0);
      add(0, 0, 0, 1, 0, 4, 1, 0);
      add(0, 0, 0, 1, 0, 3, 1, 0);
      add(0, 0, 0, 1, 0, 2, 1, 0);
      add(0, 0, 0, 1, 1, 2, 0, 0);
      add(0, 0, 0, 1, 1, 2, 0, 0);
      add(1, 0, 1, 1, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 0);

      rst_n = 1'b0;
      load_valid = 0; load_value = '0; auto_reload = 0; en = 0; abort = 0;
      model_reset();
      #12;
      check("reset.count", 32'(count), 0);
      check("reset.busy", 32'(busy), 0);
      check("reset.tc", 32'(tc), 0);
      check("reset.ready", 32'(load_ready), 1);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].lv, vecs[i].lval, vecs[i].ar, vecs[i].e, vecs[i].ab);
         check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d.tc", i), 32'(tc), 32'(vecs[i].exp_tc));
         check($sformatf("vec%0d.ready", i), 32'(load_ready), 32'(!vecs[i].exp_busy));
      end

      // asynchronous reset mid-run at count 3
      step(1, 5, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      check("pre_rst.count", 32'(count), 3);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst.count", 32'(count), 0);
      check("async_rst.busy", 32'(busy), 0);
      check("async_rst.tc", 32'(tc), 0);
      check("async_rst.ready", 32'(load_ready), 1);
      #2 rst_n = 1'b1;
      step(1, 2, 0, 1, 0);
      check("post_rst.load", 32'(count), 2);
      check_model("post_rst");
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      check("post_rst.tc", 32'(tc), 1);
      check_model("post_rst_end");

      // all-ones load: tc after exactly 15 decrements
      step(1, 15, 0, 1, 0);
      check("max.load", 32'(count), 15);
      for (int k = 1; k <= 15; k++) begin
         step(0, 0, 0, 1, 0);
         check($sformatf("max.dec%0d.tc", k), 32'(tc), (k == 15) ? 1 : 0);
         check($sformatf("max.dec%0d.count", k), 32'(count), 32'(15 - k));
      end

      // reload of 1: tc every cycle until abort
      step(1, 1, 1, 1, 0);
      check("div1.load.tc", 32'(tc), 0);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 1, 0);
         check($sformatf("div1.%0d.tc", k), 32'(tc), 1);
         check($sformatf("div1.%0d.count", k), 32'(count), 1);
      end
      step(0, 0, 0, 1, 1);
      check("div1.abort.tc", 32'(tc), 0);
      check("div1.abort.busy", 32'(busy), 0);

      // random traffic against the model
      for (int k = 0; k < 600; k++) begin
         step(($urandom % 3) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
              ($urandom % 4) != 0, ($urandom % 16) == 0);
         check_model($sformatf("rand%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable synchronous down-counter/timer. It is the counting-down counterpart of the team's 4-bit ripple up-counter.
- Accepts a start value over a valid/ready load handshake and decrements once per enabled cycle.
- Pulses a terminal-count flag when the count expires. With auto-reload it acts as a programmable divide-by-N tick source.
- Decrement datapath is a ripple-borrow chain built from the team's full_adder cell: count + all-ones, carry-in 0.

Parameters:
WIDTH, 4, counter and load value width in bits (minimum 2)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
load_valid  input  1  requester presents load_value/auto_reload
load_ready  output  1  block can accept a load (high only in IDLE)
load_value  input  WIDTH  start count, unsigned
auto_reload  input  1  sampled with load: 1 = reload and keep running at expiry
en  input  1  count enable; 0 freezes count in RUN
abort  input  1  stop current run without terminal count
count  output  WIDTH  current count value, registered
busy  output  1  high while in RUN
tc  output  1  terminal-count pulse, registered, one cycle per expiry

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - state=IDLE, count=0, reload_reg=0, ar_reg=0, tc=0, busy=0, load_ready=1.
  - On release, first edge behaves as IDLE.
- States are IDLE and RUN. busy = (state==RUN). load_ready = (state==IDLE). Both are combinational from state.
- IDLE:
  - On edge with load_valid & load_ready: count<=load_value, reload_reg<=load_value, ar_reg<=auto_reload.
  - load_value != 0: next state RUN, tc<=0.
  - load_value == 0: stay IDLE, count<=0, tc<=1 for exactly one cycle. Applies regardless of auto_reload; there is no zero-period run.
  - No load accepted: count holds, tc<=0.
  - abort and en have no effect in IDLE.
- RUN, evaluated at each edge in priority order:
  1. abort=1: next state IDLE, count holds its current value, tc<=0.
  2. en=0: count holds, tc<=0.
  3. en=1 and count>1: count<=count-1, tc<=0.
  4. en=1 and count==1, ar_reg=1: count<=reload_reg, tc<=1, stay RUN.
  5. en=1 and count==1, ar_reg=0: count<=0, tc<=1, next state IDLE. busy falls and load_ready rises in the same cycle tc is high.
- load_valid during RUN is ignored (not accepted, no side effects). auto_reload changes during RUN are ignored; only ar_reg is used.
- Latency:
  - Load accepted at edge E: count=load_value after E.
  - First decrement occurs at the first edge after E with en=1.
  - Non-reload, en held high: tc is high in cycle E+load_value.
- Auto-reload period:
  - With en held high, tc period = reload_reg cycles.
  - Count sequence is N, N-1, …, 1, N, … and never shows 0.
  - reload_reg=1 gives tc high every cycle.
- Arithmetic: unsigned modulo 2^WIDTH. Count never decrements below 0 because expiry is detected at 1, so there is no wrap. Maximum period = 2^WIDTH-1.
- Reset asserted mid-run: immediate return to reset values. Any pending tc is lost.
- tc is never asserted on an abort edge or on a reset.

Test Plan:
- Run active at count=3, pull rst_n low between edges -> count=0, busy=0, tc=0, load_ready=1 without a clock edge; after release, a load of 2 is accepted normally.
- WIDTH=4, load 5, auto_reload=0, en=1 -> count 5,4,3,2,1,0 on successive cycles; tc=1 only in the cycle count=0, busy=0 and load_ready=1 in that cycle; tc=0 the next cycle.
- Load 3, auto_reload=1, en=1 for 10 cycles -> count 3,2,1,3,2,1,3,2,1,3; tc high exactly when count reloads to 3 (every 3rd cycle); busy stays 1.
- Load 4, en dropped for 2 cycles while count=3, load_valid=1 with load_value=9 during RUN -> count holds 3 for 2 cycles, load ignored (load_ready=0), tc arrives 2 cycles later than the uninterrupted case.
- Load 6, abort at count=2 -> next state IDLE, count stays 2, tc never asserted; then load 0 -> tc=1 for one cycle, busy stays 0, count=0.
- Load 15 (all ones), en=1 -> tc after exactly 15 decrements; then load 1 with auto_reload=1 -> tc high every cycle until abort.
